// File: rtl/circle_anim_if.sv
// circle_anim control/display bundle.
// Master drives the step controls; slave (the animator) drives the pins.
interface circle_anim_if #(
  parameter int DIGITS = 4,
  parameter int PW     = $clog2(2*DIGITS+4)
);
  logic              tick_i;
  logic              en_i;
  logic              dir_i;
  logic              clr_i;
  logic [PW-1:0]     pos_o;
  logic              busy_o;
  logic [DIGITS-1:0] an_o;
  logic [6:0]        seg_o;

  modport master (
    output tick_i, en_i, dir_i, clr_i,
    input  pos_o, busy_o, an_o, seg_o
  );

  modport slave (
    input  tick_i, en_i, dir_i, clr_i,
    output pos_o, busy_o, an_o, seg_o
  );
endinterface

// File: rtl/circle_anim.sv
// Spinning-segment ring animation on a multiplexed 7-seg display.
// Optional tail segment at the previous position: define TRAIL_EN.
module circle_anim #(
  parameter int DIGITS     = 4,
  parameter int SCAN_W     = 10,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  circle_anim_if.slave bus
);
  localparam int L  = 2*DIGITS+4;
  localparam int PW = $clog2(L);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] LAST = PW'(L-1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic              busy_q;
  logic              tick_q;
  logic              step;
  logic              adv;
  logic [SCAN_W-1:0] scan_q;
  logic [DW-1:0]     dig_q, dig_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [6:0]        lit;

  // Segment of ring position p that belongs to digit d (0 if elsewhere).
  function automatic logic [6:0] ring_seg(
    input logic [PW-1:0] p,
    input logic [DW-1:0] d
  );
    int pi;
    int dg;
    int sg;
    pi = int'(p);
    dg = 0;
    sg = 7;
    if (pi < DIGITS) begin
      dg = DIGITS-1-pi;
      sg = 0;
    end else if (pi == DIGITS) begin
      sg = 1;
    end else if (pi == DIGITS+1) begin
      sg = 2;
    end else if (pi <= 2*DIGITS+1) begin
      dg = pi-DIGITS-2;
      sg = 3;
    end else if (pi == 2*DIGITS+2) begin
      dg = DIGITS-1;
      sg = 4;
    end else if (pi == 2*DIGITS+3) begin
      dg = DIGITS-1;
      sg = 5;
    end
    if (dg == int'(d)) ring_seg = 7'b1 << sg;
    else ring_seg = '0;
  endfunction

  assign step = bus.tick_i & ~tick_q;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    adv     = 1'b0;
    if (bus.clr_i) begin
      state_d = IDLE;
      pos_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pos_d = '0;
          if (bus.en_i) state_d = RUN;
        end
        RUN: begin
          if (!bus.en_i) state_d = PAUSE;
          else adv = step;
        end
        PAUSE: begin
          if (bus.en_i) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
    if (adv) begin
      if (bus.dir_i)
        pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
      else
        pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
    end
  end

`ifdef TRAIL_EN
  logic          trail_q, trail_d;
  logic [PW-1:0] tail;

  always_comb begin
    if (bus.dir_i)
      tail = (pos_q == LAST) ? '0 : pos_q + 1'b1;
    else
      tail = (pos_q == '0) ? LAST : pos_q - 1'b1;
    trail_d = (state_d == IDLE) ? 1'b0 : (trail_q | adv);
    lit = ring_seg(pos_q, dig_q);
    if (trail_q) lit = lit | ring_seg(tail, dig_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trail_q <= 1'b0;
    else trail_q <= trail_d;
  end
`else
  assign lit = ring_seg(pos_q, dig_q);
`endif

  always_comb begin
    dig_d = dig_q;
    if (&scan_q)
      dig_d = (dig_q == DW'(DIGITS-1)) ? '0 : dig_q + 1'b1;
    an_d  = (DIGITS'(1) << dig_q) ^ {DIGITS{ACTIVE_LOW}};
    seg_d = (state_q == IDLE) ? 7'b0 : lit;
    seg_d = seg_d ^ {7{ACTIVE_LOW}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pos_q   <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      scan_q  <= '0;
      dig_q   <= '0;
      an_q    <= {DIGITS{ACTIVE_LOW}};
      seg_q   <= {7{ACTIVE_LOW}};
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      busy_q  <= (state_d == RUN);
      tick_q  <= bus.tick_i;
      scan_q  <= scan_q + 1'b1;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.pos_o  = pos_q;
  assign bus.busy_o = busy_q;
  assign bus.an_o   = an_q;
  assign bus.seg_o  = seg_q;
endmodule

// File: tb/tb_circle_anim.sv
// Directed bench for circle_anim (DIGITS=4, SCAN_W=2, active-high).
// Expected values are queued with the stimulus and popped at each check.
module tb_circle_anim;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  circle_anim_if #(.DIGITS(4)) bus ();

  circle_anim #(
    .DIGITS    (4),
    .SCAN_W    (2),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

`ifdef TRAIL_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty obs=%0h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic pulse();
    bus.tick_i = 1'b1;
    cyc();
    bus.tick_i = 1'b0;
    cyc();
  endtask

  task automatic wait_an(input logic [3:0] v, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.an_o === v) begin
        hit = 1'b1;
        break;
      end
      cyc();
    end
    push(tag, 1);
    pop_chk({31'b0, hit});
  endtask

  initial begin
    int n;
    int leak;
    int lit_cnt;
    bus.tick_i = 1'b0;
    bus.en_i   = 1'b0;
    bus.dir_i  = 1'b0;
    bus.clr_i  = 1'b0;
    repeat (2) cyc();

    push("rst_pos", 0);  pop_chk(32'(bus.pos_o));
    push("rst_busy", 0); pop_chk(32'(bus.busy_o));
    push("rst_an", 0);   pop_chk(32'(bus.an_o));
    push("rst_seg", 0);  pop_chk(32'(bus.seg_o));

    rst_n = 1'b1;
    cyc();
    push("idle_busy", 0); pop_chk(32'(bus.busy_o));
    bus.en_i = 1'b1;
    cyc();
    push("run_busy", 1); pop_chk(32'(bus.busy_o));
    push("run_pos0", 0); pop_chk(32'(bus.pos_o));

    // Start-of-run display: only head at pos 0 (a of digit 3), no tail yet
    wait_an(4'b1000, "wait_d3_start");
    push("start_seg", 7'b0000001); pop_chk(32'(bus.seg_o));

    for (int i = 0; i < 12; i++) begin
      push($sformatf("cw_pos%0d", i), (i+1) % 12);
      pulse();
      pop_chk(32'(bus.pos_o));
    end

    push("held_tick", 1);
    bus.tick_i = 1'b1;
    repeat (10) cyc();
    bus.tick_i = 1'b0;
    cyc();
    pop_chk(32'(bus.pos_o));

    for (int i = 2; i <= 4; i++) begin
      push($sformatf("cw_to4_%0d", i), i);
      pulse();
      pop_chk(32'(bus.pos_o));
    end

    // pos 4 = b of digit 0
    wait_an(4'b0010, "wait_d1");
    wait_an(4'b0001, "wait_d0");
    push("p4_seg", TR ? 7'b0000011 : 7'b0000010);
    pop_chk(32'(bus.seg_o));
    n = 0;
    while (bus.an_o === 4'b0001 && n < 10) begin
      n++;
      cyc();
    end
    push("dwell", 4); pop_chk(n);
    leak = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.an_o !== 4'b0001 && bus.seg_o !== 7'b0) leak++;
      cyc();
    end
    push("p4_leak", 0); pop_chk(leak);

    bus.dir_i = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      push($sformatf("ccw_pos%0d", i), i);
      pulse();
      pop_chk(32'(bus.pos_o));
    end
    push("ccw_wrap", 11);
    pulse();
    pop_chk(32'(bus.pos_o));
    wait_an(4'b1000, "wait_d3");
    push("p11_seg", TR ? 7'b0100001 : 7'b0100000);
    pop_chk(32'(bus.seg_o));

    // Step edge in the same cycle as en drop is swallowed
    push("pause_pos", 11);
    push("pause_busy", 0);
    bus.en_i   = 1'b0;
    bus.tick_i = 1'b1;
    cyc();
    bus.tick_i = 1'b0;
    cyc();
    pop_chk(32'(bus.pos_o));
    pop_chk(32'(bus.busy_o));
    push("pause_ign", 11);
    pulse();
    pop_chk(32'(bus.pos_o));
    push("resume_busy", 1);
    bus.en_i = 1'b1;
    cyc();
    pop_chk(32'(bus.busy_o));

    push("clr_pos", 0);
    push("clr_busy", 0);
    bus.en_i   = 1'b0;
    bus.clr_i  = 1'b1;
    bus.tick_i = 1'b1;
    cyc();
    bus.clr_i  = 1'b0;
    bus.tick_i = 1'b0;
    cyc();
    pop_chk(32'(bus.pos_o));
    pop_chk(32'(bus.busy_o));

    leak = 0;
    lit_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.seg_o !== 7'b0) leak++;
      if (bus.an_o !== 4'b0) lit_cnt++;
      cyc();
    end
    push("idle_seg_off", 0); pop_chk(leak);
    push("idle_an_scan", 8); pop_chk(lit_cnt);

    bus.en_i  = 1'b1;
    bus.dir_i = 1'b0;
    cyc();
    for (int i = 1; i <= 5; i++) begin
      push($sformatf("rerun_pos%0d", i), i);
      pulse();
      pop_chk(32'(bus.pos_o));
    end

    push("arst_pos", 0);
    push("arst_busy", 0);
    push("arst_an", 0);
    push("arst_seg", 0);
    rst_n = 1'b0;
    #1;
    pop_chk(32'(bus.pos_o));
    pop_chk(32'(bus.busy_o));
    pop_chk(32'(bus.an_o));
    pop_chk(32'(bus.seg_o));
    cyc();
    rst_n = 1'b1;
    cyc();

    push("sb_drained", 0);
    pop_chk(sb.size() - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
